// File: rtl/clk_div_monitor.sv
// Measures period and high time of an asynchronous divided clock in clk cycles.
// Define CLK_DIV_MON_DUTY_EN to build the high-time counter; otherwise high_time is tied to 0.
module clk_div_monitor #(
    parameter int CW          = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          div_in,
    input  logic          run,
    input  logic [CW-1:0] exp_period,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic          valid,
    output logic          match,
    output logic          busy,
    output logic          timeout
);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   div_s, div_d, rise;
    logic [CW-1:0]          cnt, cnt_inc;
    logic                   sat;

    assign div_s   = sync[SYNC_STAGES-1];
    assign rise    = div_s & ~div_d;
    assign cnt_inc = cnt + ONE;
    assign sat     = &cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            div_d <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], div_in};
            div_d <= div_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = ARM;
            ARM:     if (!run) state_nxt = IDLE;
                     else if (rise) state_nxt = MEASURE;
            MEASURE: if (!run) state_nxt = IDLE;
                     else if (!rise && sat) state_nxt = ARM;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // A rise always wins over saturation, so a period of exactly 2^CW completes (wrapping to 0).
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            period  <= '0;
            match   <= 1'b0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: if (run) begin
                    cnt     <= '0;
                    timeout <= 1'b0;
                end
                ARM: if (run) begin
                    if (rise) cnt <= '0;
                    else if (sat) begin
                        cnt     <= '0;
                        timeout <= 1'b1;
                    end else cnt <= cnt_inc;
                end
                MEASURE: if (run) begin
                    if (rise) begin
                        period <= cnt_inc;
                        match  <= (cnt_inc == exp_period);
                        valid  <= 1'b1;
                        cnt    <= '0;
                    end else if (sat) begin
                        cnt     <= '0;
                        timeout <= 1'b1;
                    end else cnt <= cnt_inc;
                end
                default: ;
            endcase
        end
    end

`ifdef CLK_DIV_MON_DUTY_EN
    logic [CW-1:0] hcnt;

    // hcnt starts at 1 because the rise cycle itself is the first high cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt      <= '0;
            high_time <= '0;
        end else if (run && state != IDLE) begin
            if (rise) begin
                if (state == MEASURE) high_time <= hcnt;
                hcnt <= ONE;
            end else if (state == MEASURE && div_s && !sat) begin
                hcnt <= hcnt + ONE;
            end
        end
    end
`else
    assign high_time = '0;
`endif

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Measures a divided clock against the system clock. It reports the period and high time of `div_in` in `clk` cycles, and flags whether the period matches an expected value. It sits at the output of the programmable frequency divider as its consumer-side checker: it recovers the effective division ratio and duty cycle for self-test and ratio verification.

## Interface
- `CW`, default 16, width of period/high-time counters and results.
- `SYNC_STAGES`, default 2, synchronizer flops on `div_in` (minimum 2).

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `div_in`  in  1  divided clock under test, asynchronous to `clk`.
- `run`  in  1  level; high = measure continuously, low = abort and idle.
- `exp_period`  in  CW  expected period in `clk` cycles.
- `period`  out  CW  last measured period.
- `high_time`  out  CW  last measured high time.
- `valid`  out  1  one-cycle pulse; new `period`/`high_time`/`match` written.
- `match`  out  1  `period == exp_period` at last `valid`.
- `busy`  out  1  high when not in IDLE.
- `timeout`  out  1  sticky; counter saturated without a rising edge.

## Operation
- **Synchronizer**
  - `div_in` passes through `SYNC_STAGES` flops to give `div_s`, then one more flop to give `div_d`.
  - `rise = div_s & ~div_d`.
  - All synchronizer flops reset to 0.
- **States:** IDLE, ARM, MEASURE.
  - IDLE: `busy`=0. On `run`=1, go to ARM, clear `cnt` and `timeout`.
  - ARM: wait for first `rise`. `cnt` increments each cycle. On `rise`, go to MEASURE with `cnt`<=0 and `hcnt`<=1.
  - MEASURE: on a cycle with no `rise`, `cnt`<=`cnt`+1, and `hcnt`<=`hcnt`+1 if `div_s`=1.
  - MEASURE on `rise`:
    - `period`<=`cnt`+1, `high_time`<=`hcnt`, `match`<=(`cnt`+1==`exp_period`), `valid`<=1.
    - Then `cnt`<=0, `hcnt`<=1, and remain in MEASURE (back-to-back periods, no gap).
  - `run`=0 in any state: go to IDLE next cycle. No `valid` for a partial period. `period`/`high_time`/`match` hold their last values.
- **Saturation**
  - If `cnt` reaches all-ones in ARM or MEASURE with no `rise` that cycle: set `timeout`, go to ARM, and clear `cnt`.
  - `timeout` stays set until reset or the next IDLE->ARM transition.
- **Arithmetic**
  - Unsigned, CW bits.
  - A measurable period lies in 2..2^CW-1.
  - `hcnt` cannot exceed `cnt`+1, so no separate saturation is needed.
- **Simultaneous events**
  - `rise` and `run`=0 in the same cycle: abort wins, no `valid`.
  - `rise` in the same cycle `cnt` reaches all-ones: the measurement completes, no timeout.
- `reset` has priority over everything and returns to IDLE mid-measurement.

## Timing
- Reset values:
  - `period`=0, `high_time`=0, `valid`=0, `match`=0, `busy`=0, `timeout`=0.
  - `cnt`=0, `hcnt`=0, state IDLE.
- `div_in` edge to `rise`: SYNC_STAGES+1 cycles (+1 for async uncertainty).
- `rise` to `valid`: `valid` and the updated results appear the cycle after the `rise` cycle (registered).
- Steady state: with a constant period P, `valid` pulses every P cycles.
- First `valid`: one full period after the first `rise` following `run`.
- `busy` rises the cycle after `run` rises and falls the cycle after `run` falls.
- Resolution: one `clk` cycle. The half-cycle component of odd divide ratios appears as ±1 jitter in `high_time`.

## Configuration
- `CLK_DIV_MON_DUTY_EN` defined:
  - `hcnt` and the `high_time` register are built, as described above.
- Not defined:
  - `hcnt` is removed and `high_time` is tied to 0.
  - `period`, `match`, `valid` and `timeout` behave identically.

## Test plan
- `div_in` 2 high / 2 low, `run`=1, `exp_period`=4 -> `valid` every 4 cycles, `period`=4, `high_time`=2, `match`=1.
- `div_in` 3 high / 2 low, `exp_period`=4 -> `period`=5, `high_time`=3, `match`=0. With macro undefined, `high_time`=0.
- CW=8, `div_in` held low, `run`=1 -> `timeout`=1 after 255 cycles, no `valid`, state re-arms. Toggle `run` low/high -> `timeout` cleared.
- `run` dropped 2 cycles into an 8-cycle period -> no `valid`, `busy`=0 next cycle, `period` retains prior value 8.
- `reset` asserted mid-MEASURE -> all outputs 0 next cycle. After release, `run`=1 yields the first `valid` one full period after the first `rise`.
- Period changes 6 -> 10 on the fly -> one `valid` with `period`=6, then `valid` pulses with `period`=10 and no dropped pulse.
